// File: rtl/arb_pkg.sv
// Shared definitions for the IWRR arbiter: FSM encoding and the rotating-priority
// first-set search used by the picker.
package arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int RR_MAX_W   = 32;
    localparam int RR_IDX_W   = $clog2(RR_MAX_W);

    // One-hot of the first set bit of vec[n-1:0], searching upward from ptr and wrapping.
    function automatic logic [RR_MAX_W-1:0] rr_pick(
        input logic [RR_MAX_W-1:0] vec,
        input int                  ptr,
        input int                  n
    );
        logic [RR_MAX_W-1:0] res;
        logic                found;
        logic [RR_IDX_W-1:0] idx;
        int                  idx_i;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX_W; k++) begin
            if (k < n) begin
                idx_i = ptr + k;
                if (idx_i >= n) begin
                    idx_i = idx_i - n;
                end
                idx = idx_i[RR_IDX_W-1:0];
                if (!found && vec[idx]) begin
                    res[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_iwrr_rr_pick.sv
// Combinational rotating-priority picker: one-hot of the first set bit of i_vec
// at or above i_ptr, wrapping to bit 0.
module arb_iwrr_rr_pick
    import arb_pkg::*;
#(
    parameter int P_N = 4
) (
    input  logic [P_N-1:0]         i_vec,
    input  logic [$clog2(P_N)-1:0] i_ptr,
    output logic [P_N-1:0]         o_onehot
);

    logic [RR_MAX_W-1:0] w_vec;
    logic [RR_MAX_W-1:0] w_pick;

    assign w_vec    = RR_MAX_W'(i_vec);
    assign w_pick   = rr_pick(w_vec, int'(i_ptr), P_N);
    assign o_onehot = w_pick[P_N-1:0];

    generate
        if (P_N < RR_MAX_W) begin : g_hi
            logic w_unused_hi;
            assign w_unused_hi = |w_pick[RR_MAX_W-1:P_N];
        end
    endgenerate

endmodule

// File: rtl/arb_iwrr_sched.sv
// Interleaved weighted round-robin arbiter with a registered, sticky valid/ready grant.
// Each requester gets up to its weight of grants per round, one per pointer turn.
module arb_iwrr_sched
    import arb_pkg::*;
#(
    parameter  int P_REQUESTER_NUM = 4,
    parameter  int P_WEIGHT_W      = 4,
    localparam int P_ID_W          = $clog2(P_REQUESTER_NUM)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [P_REQUESTER_NUM-1:0]          i_request,
    input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] i_weight,
    output logic [P_REQUESTER_NUM-1:0]          o_grant,
    output logic [P_ID_W-1:0]                   o_grant_id,
    output logic                                o_grant_valid,
    input  logic                                i_grant_ready,
    output logic                                o_round_start
);

    logic [0:0]                 r_state;
    logic [P_REQUESTER_NUM-1:0] r_grant;
    logic [P_ID_W-1:0]          r_grant_id;
    logic                       r_grant_valid;
    logic                       r_round_start;
    logic [P_ID_W-1:0]          r_ptr;
    logic                       r_fresh;

    logic                       w_hs;
    logic                       w_arb;
    logic                       w_any_req;
    logic                       w_rollover;
    logic                       w_load_w;
    logic [P_REQUESTER_NUM-1:0] w_valid;
    logic [P_REQUESTER_NUM-1:0] w_pick_in;
    logic [P_REQUESTER_NUM-1:0] w_pick;
    logic [P_ID_W-1:0]          w_pick_id;
    logic [P_ID_W-1:0]          w_ptr_next;

    assign w_hs       = r_grant_valid & i_grant_ready;
    assign w_arb      = (r_state == ST_IDLE) | w_hs;
    assign w_any_req  = |i_request;
    assign w_rollover = w_any_req & ~|w_valid;
    // r_fresh makes the first cycle after reset see the weight input directly.
    assign w_load_w   = r_fresh | (w_arb & w_rollover);
    assign w_pick_in  = w_rollover ? i_request : w_valid;

    genvar gi;
    generate
        for (gi = 0; gi < P_REQUESTER_NUM; gi++) begin : g_req
            logic [P_WEIGHT_W-1:0] r_cnt;
            logic [P_WEIGHT_W-1:0] r_weight;
            logic [P_WEIGHT_W-1:0] w_wt;
            logic [P_WEIGHT_W-1:0] w_eff;

            assign w_wt        = r_fresh ? i_weight[gi*P_WEIGHT_W +: P_WEIGHT_W] : r_weight;
            assign w_eff       = (w_wt == '0) ? P_WEIGHT_W'(1) : w_wt;
            assign w_valid[gi] = i_request[gi] & (r_cnt < w_eff);

            // Counted when picked, so the handshake-cycle re-arbitration already sees it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt    <= '0;
                    r_weight <= '0;
                end else begin
                    if (w_load_w) begin
                        r_weight <= i_weight[gi*P_WEIGHT_W +: P_WEIGHT_W];
                    end
                    if (w_arb) begin
                        if (w_rollover) begin
                            r_cnt <= w_pick[gi] ? P_WEIGHT_W'(1) : '0;
                        end else if (w_pick[gi] && (r_cnt != '1)) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    arb_iwrr_rr_pick #(
        .P_N      (P_REQUESTER_NUM)
    ) u_pick (
        .i_vec    (w_pick_in),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick)
    );

    always_comb begin
        w_pick_id = '0;
        for (int i = 0; i < P_REQUESTER_NUM; i++) begin
            if (w_pick[i]) begin
                w_pick_id = P_ID_W'(i);
            end
        end
    end

    assign w_ptr_next = (w_pick_id == P_ID_W'(P_REQUESTER_NUM - 1)) ? '0 : w_pick_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_round_start <= 1'b0;
            r_ptr         <= '0;
            r_fresh       <= 1'b1;
        end else begin
            r_fresh <= 1'b0;
            if (w_arb) begin
                r_round_start <= w_rollover;
                if (w_any_req) begin
                    r_state       <= ST_GRANT;
                    r_grant       <= w_pick;
                    r_grant_id    <= w_pick_id;
                    r_grant_valid <= 1'b1;
                    r_ptr         <= w_ptr_next;
                end else begin
                    r_state       <= ST_IDLE;
                    r_grant       <= '0;
                    r_grant_id    <= '0;
                    r_grant_valid <= 1'b0;
                end
            end else begin
                r_round_start <= 1'b0;
            end
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_id    = r_grant_id;
    assign o_grant_valid = r_grant_valid;
    assign o_round_start = r_round_start;

endmodule

// File: tb/tb_arb_iwrr_sched.sv
// Self-checking bench for arb_iwrr_sched: directed scenarios plus random traffic,
// all compared against a round/credit model of the arbitration rules.
module tb_arb_iwrr_sched;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   request;
    logic [N*W-1:0] weight;
    logic           grant_ready;
    logic [N-1:0]   grant;
    logic [1:0]     grant_id;
    logic           grant_valid;
    logic           round_start;

    int errors = 0;
    int checks = 0;

    // Model: grants used this round, weights of this round, turn pointer, current output.
    int m_used[N];
    int m_wts[N];
    int m_ptr;
    int m_id;
    bit m_valid;
    bit m_rs;

    always #5 clk = ~clk;

    arb_iwrr_sched #(
        .P_REQUESTER_NUM (N),
        .P_WEIGHT_W      (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_request     (request),
        .i_weight      (weight),
        .o_grant       (grant),
        .o_grant_id    (grant_id),
        .o_grant_valid (grant_valid),
        .i_grant_ready (grant_ready),
        .o_round_start (round_start)
    );

    function automatic int quota(input int w);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = m_valid ? (4'b0001 << m_id) : 4'b0000;
        return {g, 2'(m_id), m_valid, m_rs};
    endfunction

    function automatic logic [7:0] act_vec();
        return {grant, grant_id, grant_valid, round_start};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_used[i] = 0;
            m_wts[i]  = int'(weight[i*W +: W]);
        end
        m_ptr   = 0;
        m_id    = 0;
        m_valid = 1'b0;
        m_rs    = 1'b0;
    endtask

    // Advances the model across one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit any;
        int pick;
        int idx;
        if (m_valid && !grant_ready) begin
            m_rs = 1'b0;
            return;
        end
        if (request == '0) begin
            m_valid = 1'b0;
            m_id    = 0;
            m_rs    = 1'b0;
            return;
        end
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (request[i] && m_used[i] < quota(m_wts[i])) any = 1'b1;
        end
        if (!any) begin
            for (int i = 0; i < N; i++) begin
                m_used[i] = 0;
                m_wts[i]  = int'(weight[i*W +: W]);
            end
        end
        pick = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (pick < 0 && request[idx] && m_used[idx] < quota(m_wts[idx])) pick = idx;
        end
        m_used[pick] = (m_used[pick] < 15) ? m_used[pick] + 1 : 15;
        m_ptr   = (pick + 1) % N;
        m_id    = pick;
        m_valid = 1'b1;
        m_rs    = !any;
    endtask

    task automatic step();
        @(posedge clk);
        if (m_valid && grant_ready) begin
            $display("txn t=%0t grant_id=%0d accepted", $time, m_id);
        end
        model_edge();
        #1;
    endtask

    task automatic do_reset(input logic [N*W-1:0] w);
        weight      = w;
        request     = '0;
        grant_ready = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        weight      = 16'h1111;
        request     = '0;
        grant_ready = 1'b0;
        rst_n       = 1'b0;
        #12;
        model_reset();
        checks++;
        if (act_vec() !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %b want 00000000", act_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %b want %b", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_equal_weights();
        int exp_ids[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        do_reset(16'h1111);
        request     = 4'hF;
        grant_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL equal_model[%0d]: got %b want %b", i, act_vec(), exp_vec());
            end
            checks++;
            if (grant_id !== 2'(exp_ids[i]) || round_start !== (i == 4)) begin
                errors++;
                $display("FAIL equal_seq[%0d]: got id=%0d rs=%0b want id=%0d rs=%0b",
                         i, grant_id, round_start, exp_ids[i], (i == 4));
            end
        end
    endtask

    task automatic test_weighted();
        int exp_ids[7] = '{0, 1, 2, 3, 0, 0, 1};
        do_reset(16'h1113);
        request     = 4'hF;
        grant_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL weighted_model[%0d]: got %b want %b", i, act_vec(), exp_vec());
            end
            checks++;
            if (grant_id !== 2'(exp_ids[i]) || round_start !== (i == 6)) begin
                errors++;
                $display("FAIL weighted_seq[%0d]: got id=%0d rs=%0b want id=%0d rs=%0b",
                         i, grant_id, round_start, exp_ids[i], (i == 6));
            end
        end
    endtask

    task automatic test_single_requester();
        do_reset(16'h0200);
        request     = 4'b0100;
        grant_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (grant_id !== 2'd2 || grant_valid !== 1'b1 || grant !== 4'b0100 ||
                round_start !== (i > 0 && i % 2 == 0)) begin
                errors++;
                $display("FAIL single[%0d]: got g=%b id=%0d v=%0b rs=%0b want g=0100 id=2 v=1 rs=%0b",
                         i, grant, grant_id, grant_valid, round_start, (i > 0 && i % 2 == 0));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(16'h1111);
        request = 4'b0010;
        step();
        request = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (grant !== 4'b0010 || grant_id !== 2'd1 || grant_valid !== 1'b1 ||
                act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %b want %b", i, act_vec(), exp_vec());
            end
        end
        request     = 4'b0011;
        grant_ready = 1'b1;
        step();
        checks++;
        if (grant_id !== 2'd0 || grant_valid !== 1'b1 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stall_release: got id=%0d v=%0b want id=0 v=1", grant_id, grant_valid);
        end
        step();
        checks++;
        if (grant_id !== 2'd1 || round_start !== 1'b1 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stall_rollover: got id=%0d rs=%0b want id=1 rs=1", grant_id, round_start);
        end
    endtask

    task automatic test_weight_change();
        do_reset(16'h1111);
        request     = 4'hF;
        grant_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 1) weight = 16'h2222;
            checks++;
            if (grant_id !== 2'(i % 4) || round_start !== (i == 4 || i == 12) ||
                act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL weight_change[%0d]: got id=%0d rs=%0b want id=%0d rs=%0b",
                         i, grant_id, round_start, i % 4, (i == 4 || i == 12));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(16'h1111);
        request     = 4'hF;
        grant_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (act_vec() !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b want 00000000", act_vec());
        end
        request = 4'b1100;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (grant_id !== 2'd2 || grant_valid !== 1'b1 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL async_first: got id=%0d v=%0b want id=2 v=1", grant_id, grant_valid);
        end
    endtask

    task automatic test_random();
        do_reset(N*W'($urandom));
        for (int i = 0; i < 500; i++) begin
            request     = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            grant_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) weight = 16'($urandom);
            step();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %b want %b", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal_weights();
        test_weighted();
        test_single_requester();
        test_stall();
        test_weight_change();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
